// File: rtl/nebula_pkg.sv
// Shared Nebula config-bus definitions: AXI-Lite response codes, bus width
// defaults and the initiator FSM state type.
package nebula_pkg;

  localparam int NEBULA_ADDR_W = 32;
  localparam int NEBULA_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_e;

endpackage

// File: rtl/nebula_sat_counter.sv
// Saturating up-counter: advances by one per inc_i pulse and sticks at all-ones.
module nebula_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/nebula_axil_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one register access
// on the config bus, one response out, with a per-transaction timeout.
module nebula_axil_master
  import nebula_pkg::*;
#(
  parameter int ADDR_W  = NEBULA_ADDR_W,
  parameter int DATA_W  = NEBULA_DATA_W,
  parameter int TIMEOUT = 256,
  parameter int STRAY_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_bvalid,
  input  logic [1:0]            m_bresp,
  output logic                  m_bready,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  m_rready,
  output logic [STRAY_W-1:0]    stray_cnt
);

  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam int TW     = TMO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EN ? TIMEOUT - 1 : 0);

  state_e                state_q, state_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  tmo_q, tmo_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  cap;
  logic                  tmo_hit;
  logic                  b_accept, r_accept;
  logic                  stray_inc;

  assign tmo_hit = TMO_EN && (tcnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    tmo_d   = tmo_q;
    cap     = 1'b0;
    if (TMO_EN && (state_q != IDLE) && (state_q != DONE)) begin
      tcnt_d = tcnt_q + TW'(1);
    end
    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (cmd_valid) begin
          cap     = 1'b1;
          state_d = cmd_we ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ, WR_RESP: begin
        // A response on the expiry cycle still counts as a normal completion.
        if (m_bvalid && (m_awready || (state_q == WR_RESP))) begin
          state_d = DONE;
          resp_d  = m_bresp;
          rdata_d = '0;
          tmo_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = DONE;
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          tmo_d   = 1'b1;
        end else if ((state_q == WR_REQ) && m_awready) begin
          state_d = WR_RESP;
        end
      end
      RD_REQ, RD_RESP: begin
        if (m_rvalid && (m_arready || (state_q == RD_RESP))) begin
          state_d = DONE;
          resp_d  = m_rresp;
          rdata_d = m_rdata;
          tmo_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = DONE;
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          tmo_d   = 1'b1;
        end else if ((state_q == RD_REQ) && m_arready) begin
          state_d = RD_RESP;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      tmo_q   <= tmo_d;
    end
  end

  // Request payload is only meaningful while a valid is up, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = tmo_q;

  assign m_awvalid = (state_q == WR_REQ);
  assign m_awaddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_arvalid = (state_q == RD_REQ);
  assign m_araddr  = addr_q;
  assign m_bready  = (state_q != DONE);
  assign m_rready  = (state_q != DONE);

  // Any handshaken response the FSM is not waiting for is dropped and counted.
  assign b_accept  = ((state_q == WR_REQ) && m_awready) || (state_q == WR_RESP);
  assign r_accept  = ((state_q == RD_REQ) && m_arready) || (state_q == RD_RESP);
  assign stray_inc = (m_bvalid && m_bready && !b_accept) ||
                     (m_rvalid && m_rready && !r_accept);

  nebula_sat_counter #(
    .W (STRAY_W)
  ) u_stray_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stray_inc),
    .cnt_o (stray_cnt)
  );

endmodule

// File: tb/tb_nebula_axil_master.sv
// Scoreboard bench for nebula_axil_master with TIMEOUT=16.
module tb_nebula_axil_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 16;
  localparam int SW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid, rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            rsp_timeout;
  logic            m_awvalid, m_awready;
  logic [AW-1:0]   m_awaddr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_bvalid, m_bready;
  logic [1:0]      m_bresp;
  logic            m_arvalid, m_arready;
  logic [AW-1:0]   m_araddr;
  logic            m_rvalid, m_rready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic [SW-1:0]   stray_cnt;

  nebula_axil_master #(
    .ADDR_W (AW), .DATA_W (DW), .TIMEOUT (TMO), .STRAY_W (SW)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_we (cmd_we),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout),
    .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr (m_awaddr),
    .m_wdata (m_wdata), .m_wstrb (m_wstrb),
    .m_bvalid (m_bvalid), .m_bresp (m_bresp), .m_bready (m_bready),
    .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr (m_araddr),
    .m_rvalid (m_rvalid), .m_rdata (m_rdata), .m_rresp (m_rresp), .m_rready (m_rready),
    .stray_cnt (stray_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] rdata, input logic [1:0] resp, input logic tmo);
    exp_t e;
    e.rdata = rdata;
    e.resp  = resp;
    e.tmo   = tmo;
    sb.push_back(e);
  endtask

  // Response monitor: every consumed response is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the first REQ cycle.
  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    @(negedge clk);
    chk("issue_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    m_awready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_bready", m_bready, 1'b1);
    chk("rst_rready", m_rready, 1'b1);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_resp", rsp_resp, 2'b00);
    chk("rst_timeout", rsp_timeout, 1'b0);
    chk("rst_stray", stray_cnt, 8'd0);
    step();
    rst = 1'b0;
    step();

    // Zero-wait write
    push_exp(32'd0, 2'b00, 1'b0);
    issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    m_awready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge clk);
    chk("wr_awvalid", m_awvalid, 1'b1);
    chk("wr_awaddr", m_awaddr, 32'h4);
    chk("wr_wdata", m_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", m_wstrb, 4'hF);
    chk("wr_rsp_early", rsp_valid, 1'b0);
    step();
    m_awready = 1'b0; m_bvalid = 1'b0;
    @(negedge clk);
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_cmd_ready", cmd_ready, 1'b0);
    chk("wr_bready_done", m_bready, 1'b0);
    step();

    // Read with delayed arready and rvalid, response held off for two cycles
    push_exp(32'h8, 2'b00, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_arvalid_wait", m_arvalid, 1'b1);
      chk("rd_araddr_wait", m_araddr, 32'h10);
      chk("rd_cmd_ready_req", cmd_ready, 1'b0);
      step();
    end
    m_arready = 1'b1;
    @(negedge clk);
    chk("rd_arvalid_hs", m_arvalid, 1'b1);
    chk("rd_araddr_hs", m_araddr, 32'h10);
    step();
    m_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rd_arvalid_resp", m_arvalid, 1'b0);
      chk("rd_cmd_ready_resp", cmd_ready, 1'b0);
      step();
    end
    m_rvalid = 1'b1; m_rdata = 32'h8; m_rresp = 2'b00;
    rsp_ready = 1'b0;
    step();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rd_rsp_valid_held", rsp_valid, 1'b1);
      chk("rd_cmd_ready_done", cmd_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rd_cmd_ready_after", cmd_ready, 1'b1);
    step();

    // Hung responder: awready never rises
    push_exp(32'd0, 2'b10, 1'b1);
    issue(1'b1, 32'h20, 32'h11223344, 4'h3);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      n++;
      step();
    end
    chk("tmo_seen", got, 1'b1);
    chk("tmo_latency", n, TMO);
    chk("tmo_awvalid_low", m_awvalid, 1'b0);
    step();
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge clk);
    chk("late_b_stray_before", stray_cnt, 8'd0);
    step();
    m_bvalid = 1'b0;
    @(negedge clk);
    chk("late_b_stray_after", stray_cnt, 8'd1);
    step();

    // Completion on the expiry cycle (counter == TIMEOUT-1)
    push_exp(32'd0, 2'b11, 1'b0);
    issue(1'b1, 32'h24, 32'h55AA55AA, 4'h5);
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
    repeat (TMO - 2) step();
    m_bvalid = 1'b1; m_bresp = 2'b11;
    @(negedge clk);
    chk("exp_rsp_not_yet", rsp_valid, 1'b0);
    step();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    @(negedge clk);
    chk("exp_rsp_valid", rsp_valid, 1'b1);
    chk("exp_stray", stray_cnt, 8'd1);
    step();

    // Response backpressure with stray rvalid pulses and a pending command
    rsp_ready = 1'b0;
    push_exp(32'h12345678, 2'b00, 1'b0);
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b00;
    step();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h99;
      m_rvalid = i[0]; m_rdata = 32'hBAD0_0000 + 32'(i); m_rresp = 2'b10;
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 32'h12345678);
      chk("bp_resp", rsp_resp, 2'b00);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_rready", m_rready, 1'b0);
      chk("bp_stray", stray_cnt, 8'd1);
      step();
    end
    cmd_valid = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00;
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_idle_cmd_ready", cmd_ready, 1'b1);
    chk("bp_awvalid_idle", m_awvalid, 1'b0);
    chk("bp_stray_after", stray_cnt, 8'd1);
    step();

    // Reset during RD_RESP abandons the transaction
    issue(1'b0, 32'h38, 32'h0, 4'h0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    @(negedge clk);
    chk("rr_in_resp_arvalid", m_arvalid, 1'b0);
    rst = 1'b1;
    #1;
    chk("rr_arvalid", m_arvalid, 1'b0);
    chk("rr_awvalid", m_awvalid, 1'b0);
    chk("rr_rsp_valid", rsp_valid, 1'b0);
    chk("rr_cmd_ready", cmd_ready, 1'b1);
    chk("rr_stray", stray_cnt, 8'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr_post_cmd_ready", cmd_ready, 1'b1);
    chk("rr_post_rsp_valid", rsp_valid, 1'b0);
    chk("rr_post_stray", stray_cnt, 8'd0);
    step();

    // Zero-wait read with an error response after reset
    push_exp(32'hCAFEF00D, 2'b10, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b10;
    @(negedge clk);
    chk("rd2_arvalid", m_arvalid, 1'b1);
    chk("rd2_araddr", m_araddr, 32'h40);
    step();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    @(negedge clk);
    chk("rd2_rsp_valid", rsp_valid, 1'b1);
    step();
    repeat (2) step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
